// File: rtl/ps2_mouse_rx.sv
// PS/2 mouse receiver: synchronizes and filters the device clock, deframes 11-bit frames
// and assembles 3-byte movement packets. Optional macro PS2_PARITY_CHECK_EN enables parity rejection.
module ps2_mouse_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       CLK_50M,
  input  logic       RESET,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  output logic [8:0] dx,
  output logic [8:0] dy,
  output logic [2:0] buttons,
  output logic [1:0] overflow,
  output logic       packet_valid,
  output logic       frame_error
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TMO_MAX   = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic          clk_s1, clk_s2, data_s1, data_s2;
  logic          clk_filt;
  logic [FW-1:0] filt_cnt;
  logic          strobe;
  logic          parity_bad;

  state_t        state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic [1:0]    idx;
  logic [6:0]    head;
  logic [7:0]    byte1;
  logic [TW-1:0] tmo_cnt;

  // The filtered clock flips only after FILTER_LEN consecutive samples disagree with it;
  // the falling flip itself is the sample strobe, aligned with equally delayed data.
  always_ff @(posedge CLK_50M) begin
    if (RESET) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
      clk_filt <= 1'b1;
      filt_cnt <= '0;
    end else begin
      clk_s1  <= PS2_CLK;
      clk_s2  <= clk_s1;
      data_s1 <= PS2_DATA;
      data_s2 <= data_s1;
      if (clk_s2 == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_LAST) begin
        clk_filt <= clk_s2;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  assign strobe = clk_filt && !clk_s2 && (filt_cnt == FILT_LAST);

`ifdef PS2_PARITY_CHECK_EN
  logic par_bit;
  assign parity_bad = ~(^{shift, par_bit});
`else
  assign parity_bad = 1'b0;
`endif

  // head keeps only the byte-0 fields used later: {ovf[1:0], y sign, x sign, buttons[2:0]}.
  always_ff @(posedge CLK_50M) begin
    if (RESET) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      shift        <= '0;
      idx          <= '0;
      head         <= '0;
      byte1        <= '0;
      tmo_cnt      <= '0;
      dx           <= '0;
      dy           <= '0;
      buttons      <= '0;
      overflow     <= '0;
      packet_valid <= 1'b0;
      frame_error  <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      par_bit      <= 1'b0;
`endif
    end else begin
      packet_valid <= 1'b0;
      frame_error  <= 1'b0;

      if (strobe) tmo_cnt <= '0;
      else if (tmo_cnt != TMO_MAX) tmo_cnt <= tmo_cnt + 1'b1;

      if (strobe) begin
        case (state)
          IDLE: begin
            if (!data_s2) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            shift <= {data_s2, shift[7:1]};
            if (bit_cnt == 3'd7) state <= PARITY;
            else bit_cnt <= bit_cnt + 1'b1;
          end
          PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
            par_bit <= data_s2;
`endif
            state <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (!data_s2 || parity_bad) begin
              frame_error <= 1'b1;
              idx         <= '0;
            end else begin
              case (idx)
                2'd0: begin
                  if (shift[3]) begin
                    head <= {shift[7:4], shift[2:0]};
                    idx  <= 2'd1;
                  end
                end
                2'd1: begin
                  byte1 <= shift;
                  idx   <= 2'd2;
                end
                2'd2: begin
                  dx           <= {head[3], byte1};
                  dy           <= {head[4], shift};
                  buttons      <= head[2:0];
                  overflow     <= head[6:5];
                  packet_valid <= 1'b1;
                  idx          <= 2'd0;
                end
                default: idx <= 2'd0;
              endcase
            end
          end
          default: state <= IDLE;
        endcase
      end else if ((tmo_cnt == TMO_MAX) && ((state != IDLE) || (idx != 2'd0))) begin
        // A stalled device abandons the packet; only a half-received frame is an error.
        frame_error <= (state != IDLE);
        state       <= IDLE;
        idx         <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_mouse_rx.sv
// Directed self-checking bench for ps2_mouse_rx with a fast device clock and short timeout.
module tb_ps2_mouse_rx;

  localparam int HALF = 40;
  localparam int GAP  = 60;
  localparam int TMO  = 600;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [8:0] dx, dy;
  logic [2:0] buttons;
  logic [1:0] overflow;
  logic       packet_valid, frame_error;

  int checks = 0;
  int errors = 0;
  int pv_count = 0;
  int fe_count = 0;
  int both_count = 0;

  ps2_mouse_rx #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TMO)) dut (
    .CLK_50M(clk),
    .RESET(reset),
    .PS2_CLK(ps2_clk),
    .PS2_DATA(ps2_data),
    .dx(dx),
    .dy(dy),
    .buttons(buttons),
    .overflow(overflow),
    .packet_valid(packet_valid),
    .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (packet_valid) pv_count++;
    if (frame_error) fe_count++;
    if (packet_valid && frame_error) both_count++;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Device side: data changes while the clock is high, receiver samples on the falling edge.
  task automatic send_byte(input logic [7:0] b, input logic bad_par, input logic stop_bit, input int nbits);
    logic [10:0] frame;
    frame = {stop_bit, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = frame[i];
      wait_cycles(HALF);
      ps2_clk = 1'b0;
      wait_cycles(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    wait_cycles(GAP);
  endtask

  task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_byte(b0, 1'b0, 1'b1, 11);
    send_byte(b1, 1'b0, 1'b1, 11);
    send_byte(b2, 1'b0, 1'b1, 11);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    wait_cycles(5);
    checks++; if (dx !== 9'h000) begin errors++; $display("[TB] FAIL reset_dx got %h want 000", dx); end
    checks++; if (dy !== 9'h000) begin errors++; $display("[TB] FAIL reset_dy got %h want 000", dy); end
    checks++; if (buttons !== 3'b000 || overflow !== 2'b00) begin errors++; $display("[TB] FAIL reset_btn_ovf got %b/%b want 000/00", buttons, overflow); end
    checks++; if (packet_valid !== 1'b0 || frame_error !== 1'b0) begin errors++; $display("[TB] FAIL reset_pulses got %b/%b want 0/0", packet_valid, frame_error); end
    reset = 1'b0;
    wait_cycles(20);
  endtask

  task automatic test_basic_packet;
    int pv0, fe0;
    pv0 = pv_count; fe0 = fe_count;
    send_packet(8'h29, 8'h05, 8'hFB);
    checks++; if (pv_count - pv0 !== 1) begin errors++; $display("[TB] FAIL basic_pv got %0d want 1", pv_count - pv0); end
    checks++; if (fe_count - fe0 !== 0) begin errors++; $display("[TB] FAIL basic_fe got %0d want 0", fe_count - fe0); end
    checks++; if (dx !== 9'h005) begin errors++; $display("[TB] FAIL basic_dx got %h want 005", dx); end
    checks++; if (dy !== 9'h1FB) begin errors++; $display("[TB] FAIL basic_dy got %h want 1fb", dy); end
    checks++; if (buttons !== 3'b001) begin errors++; $display("[TB] FAIL basic_buttons got %b want 001", buttons); end
    checks++; if (overflow !== 2'b00) begin errors++; $display("[TB] FAIL basic_overflow got %b want 00", overflow); end
  endtask

  task automatic test_stop_error;
    int pv0, fe0;
    pv0 = pv_count; fe0 = fe_count;
    send_byte(8'h08, 1'b0, 1'b1, 11);
    send_byte(8'h33, 1'b0, 1'b0, 11);
    checks++; if (fe_count - fe0 !== 1) begin errors++; $display("[TB] FAIL stop_fe got %0d want 1", fe_count - fe0); end
    checks++; if (pv_count - pv0 !== 0) begin errors++; $display("[TB] FAIL stop_pv got %0d want 0", pv_count - pv0); end
    send_packet(8'h18, 8'h10, 8'h20);
    checks++; if (pv_count - pv0 !== 1) begin errors++; $display("[TB] FAIL stop_next_pv got %0d want 1", pv_count - pv0); end
    checks++; if (dx !== 9'h110 || dy !== 9'h020) begin errors++; $display("[TB] FAIL stop_next_xy got %h/%h want 110/020", dx, dy); end
    checks++; if (buttons !== 3'b000) begin errors++; $display("[TB] FAIL stop_next_buttons got %b want 000", buttons); end
  endtask

  task automatic test_parity_error;
    int pv0, fe0;
    pv0 = pv_count; fe0 = fe_count;
    send_byte(8'h09, 1'b0, 1'b1, 11);
    send_byte(8'h7F, 1'b0, 1'b1, 11);
    send_byte(8'h80, 1'b1, 1'b1, 11);
`ifdef PS2_PARITY_CHECK_EN
    checks++; if (fe_count - fe0 !== 1 || pv_count - pv0 !== 0) begin errors++; $display("[TB] FAIL parity_pulses got fe=%0d pv=%0d want 1/0", fe_count - fe0, pv_count - pv0); end
    checks++; if (dx !== 9'h110 || dy !== 9'h020 || buttons !== 3'b000) begin errors++; $display("[TB] FAIL parity_hold got %h/%h/%b want 110/020/000", dx, dy, buttons); end
`else
    checks++; if (fe_count - fe0 !== 0 || pv_count - pv0 !== 1) begin errors++; $display("[TB] FAIL parity_pulses got fe=%0d pv=%0d want 0/1", fe_count - fe0, pv_count - pv0); end
    checks++; if (dx !== 9'h07F || dy !== 9'h080 || buttons !== 3'b001) begin errors++; $display("[TB] FAIL parity_values got %h/%h/%b want 07f/080/001", dx, dy, buttons); end
`endif
  endtask

  task automatic test_sync_drop;
    int pv0, fe0;
    pv0 = pv_count; fe0 = fe_count;
    send_byte(8'h00, 1'b0, 1'b1, 11);
    send_packet(8'h28, 8'h01, 8'h02);
    checks++; if (pv_count - pv0 !== 1 || fe_count - fe0 !== 0) begin errors++; $display("[TB] FAIL sync_pulses got pv=%0d fe=%0d want 1/0", pv_count - pv0, fe_count - fe0); end
    checks++; if (dx !== 9'h001 || dy !== 9'h102) begin errors++; $display("[TB] FAIL sync_xy got %h/%h want 001/102", dx, dy); end
  endtask

  task automatic test_timeout;
    int pv0, fe0;
    pv0 = pv_count; fe0 = fe_count;
    send_byte(8'h08, 1'b0, 1'b1, 11);
    send_byte(8'h01, 1'b0, 1'b1, 5);
    wait_cycles(TMO + 200);
    checks++; if (fe_count - fe0 !== 1 || pv_count - pv0 !== 0) begin errors++; $display("[TB] FAIL timeout_pulses got fe=%0d pv=%0d want 1/0", fe_count - fe0, pv_count - pv0); end
    send_packet(8'h38, 8'h80, 8'h7F);
    checks++; if (pv_count - pv0 !== 1) begin errors++; $display("[TB] FAIL timeout_next_pv got %0d want 1", pv_count - pv0); end
    checks++; if (dx !== 9'h180 || dy !== 9'h17F) begin errors++; $display("[TB] FAIL timeout_next_xy got %h/%h want 180/17f", dx, dy); end
  endtask

  task automatic test_back_to_back;
    int pv0;
    pv0 = pv_count;
    send_packet(8'hCF, 8'hFF, 8'h00);
    checks++; if (dx !== 9'h0FF || dy !== 9'h000) begin errors++; $display("[TB] FAIL b2b_first_xy got %h/%h want 0ff/000", dx, dy); end
    checks++; if (buttons !== 3'b111 || overflow !== 2'b11) begin errors++; $display("[TB] FAIL b2b_first_btn_ovf got %b/%b want 111/11", buttons, overflow); end
    send_packet(8'h0C, 8'h40, 8'h41);
    checks++; if (pv_count - pv0 !== 2) begin errors++; $display("[TB] FAIL b2b_pv got %0d want 2", pv_count - pv0); end
    checks++; if (dx !== 9'h040 || dy !== 9'h041 || buttons !== 3'b100 || overflow !== 2'b00) begin errors++; $display("[TB] FAIL b2b_second got %h/%h/%b/%b want 040/041/100/00", dx, dy, buttons, overflow); end
  endtask

  task automatic test_glitch_and_reset;
    int pv0, fe0;
    pv0 = pv_count; fe0 = fe_count;
    ps2_data = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ps2_clk = 1'b0;
      wait_cycles(4);
      ps2_clk = 1'b1;
      wait_cycles(20);
    end
    ps2_data = 1'b1;
    wait_cycles(GAP);
    send_packet(8'h09, 8'h03, 8'h04);
    checks++; if (pv_count - pv0 !== 1 || fe_count - fe0 !== 0) begin errors++; $display("[TB] FAIL glitch_pulses got pv=%0d fe=%0d want 1/0", pv_count - pv0, fe_count - fe0); end
    checks++; if (dx !== 9'h003 || dy !== 9'h004 || buttons !== 3'b001) begin errors++; $display("[TB] FAIL glitch_values got %h/%h/%b want 003/004/001", dx, dy, buttons); end
    pv0 = pv_count; fe0 = fe_count;
    send_byte(8'h0A, 1'b0, 1'b1, 11);
    send_byte(8'h11, 1'b0, 1'b1, 4);
    reset = 1'b1;
    wait_cycles(3);
    reset = 1'b0;
    wait_cycles(5);
    checks++; if (dx !== 9'h000 || dy !== 9'h000 || buttons !== 3'b000 || overflow !== 2'b00) begin errors++; $display("[TB] FAIL midreset_outputs got %h/%h/%b/%b want all 0", dx, dy, buttons, overflow); end
    checks++; if (pv_count - pv0 !== 0 || fe_count - fe0 !== 0) begin errors++; $display("[TB] FAIL midreset_pulses got pv=%0d fe=%0d want 0/0", pv_count - pv0, fe_count - fe0); end
    send_packet(8'h2A, 8'h55, 8'hAA);
    checks++; if (pv_count - pv0 !== 1) begin errors++; $display("[TB] FAIL midreset_next_pv got %0d want 1", pv_count - pv0); end
    checks++; if (dx !== 9'h055 || dy !== 9'h1AA || buttons !== 3'b010) begin errors++; $display("[TB] FAIL midreset_next got %h/%h/%b want 055/1aa/010", dx, dy, buttons); end
  endtask

  initial begin
    test_reset();
    test_basic_packet();
    test_stop_error();
    test_parity_error();
    test_sync_drop();
    test_timeout();
    test_back_to_back();
    test_glitch_and_reset();
    checks++; if (both_count !== 0) begin errors++; $display("[TB] FAIL pulse_overlap got %0d want 0", both_count); end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
